// File: rtl/branch_predictor.sv
// Purpose: direct-mapped BTB with 2-bit saturating counters for the MIPS fetch
//          stage; carries each prediction into IF/ID and verifies it at ID resolve.
// Latency: lookup 0 cycles; prediction reaches ID one cycle after fetch;
//          mispredict is combinational in the resolve cycle; training is visible
//          to lookups from the next cycle.
// Backpressure: hold freezes the IF/ID prediction register; stall_compare defers
//          resolution, so no mispredict and no training occur while it is high.
//
// Ports:
//   clk, rst_n                      clock (rising edge), async active-low reset
//   fetch_pc, fetch_valid           PC being fetched and its qualifier
//   hold, flush                     IF/ID stall and flush from hazard/jump logic
//   pred_hit/pred_taken/pred_target combinational lookup result for fetch_pc
//   resolve_valid/stall_compare     ID branch present / operands not yet ready
//   resolve_taken/resolve_target    actual outcome and target from ID comparator
//   mispredict/redirect_pc          fetch redirect request and its target
module branch_predictor #(
    parameter int WIDTH      = 32,
    parameter int INDEX_BITS = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] fetch_pc,
    input  logic             fetch_valid,
    input  logic             hold,
    input  logic             flush,
    output logic             pred_hit,
    output logic             pred_taken,
    output logic [WIDTH-1:0] pred_target,
    input  logic             resolve_valid,
    input  logic             stall_compare,
    input  logic             resolve_taken,
    input  logic [WIDTH-1:0] resolve_target,
    output logic             mispredict,
    output logic [WIDTH-1:0] redirect_pc
);

    localparam int ENTRIES = 1 << INDEX_BITS;
    localparam int TAG_W   = WIDTH - INDEX_BITS - 2;

    localparam logic [1:0] CTR_WNT = 2'b01;
    localparam logic [1:0] CTR_WT  = 2'b10;
    localparam logic [1:0] CTR_ST  = 2'b11;
    localparam logic [1:0] CTR_SNT = 2'b00;

    // ------------------------------------------------------------------
    // Branch target buffer state
    // ------------------------------------------------------------------
    logic [ENTRIES-1:0] valid_q, valid_d;
    logic [TAG_W-1:0]   tag_q    [ENTRIES];
    logic [TAG_W-1:0]   tag_d    [ENTRIES];
    logic [WIDTH-1:0]   target_q [ENTRIES];
    logic [WIDTH-1:0]   target_d [ENTRIES];
    logic [1:0]         ctr_q    [ENTRIES];
    logic [1:0]         ctr_d    [ENTRIES];

    // IF/ID copy of the prediction
    logic             id_valid_q, id_valid_d;
    logic [WIDTH-1:0] id_pc_q, id_pc_d;
    logic             id_pred_taken_q, id_pred_taken_d;
    logic [WIDTH-1:0] id_pred_target_q, id_pred_target_d;

    // ------------------------------------------------------------------
    // Fetch-side lookup
    // ------------------------------------------------------------------
    logic [INDEX_BITS-1:0] f_idx;
    logic [TAG_W-1:0]      f_tag;
    logic [WIDTH-1:0]      fetch_pc_inc;

    always_comb begin
        f_idx        = fetch_pc[INDEX_BITS+1:2];
        f_tag        = fetch_pc[WIDTH-1:INDEX_BITS+2];
        fetch_pc_inc = fetch_pc + WIDTH'(4);
        pred_hit     = valid_q[f_idx] && (tag_q[f_idx] == f_tag);
        pred_taken   = pred_hit && ctr_q[f_idx][1];
        pred_target  = pred_taken ? target_q[f_idx] : fetch_pc_inc;
    end

    // ------------------------------------------------------------------
    // ID-side resolution
    // ------------------------------------------------------------------
    logic                  res_act;
    logic [INDEX_BITS-1:0] r_idx;
    logic [TAG_W-1:0]      r_tag;
    logic                  r_hit;
    logic [WIDTH-1:0]      id_pc_inc;

    always_comb begin
        res_act     = id_valid_q && !stall_compare;
        r_idx       = id_pc_q[INDEX_BITS+1:2];
        r_tag       = id_pc_q[WIDTH-1:INDEX_BITS+2];
        r_hit       = valid_q[r_idx] && (tag_q[r_idx] == r_tag);
        id_pc_inc   = id_pc_q + WIDTH'(4);
        mispredict  = 1'b0;
        redirect_pc = id_pc_inc;
        if (res_act) begin
            if (resolve_valid) begin
                mispredict = (resolve_taken != id_pred_taken_q) ||
                             (resolve_taken && (resolve_target != id_pred_target_q));
                if (mispredict && resolve_taken) begin
                    redirect_pc = resolve_target;
                end
            end else if (id_pred_taken_q) begin
                // A non-branch predicted taken means a stale/aliased entry:
                // fall through to the sequential PC.
                mispredict = 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Table training; lookups in the same cycle see pre-update contents
    // ------------------------------------------------------------------
    always_comb begin
        valid_d  = valid_q;
        tag_d    = tag_q;
        target_d = target_q;
        ctr_d    = ctr_q;
        if (res_act) begin
            if (resolve_valid) begin
                if (r_hit) begin
                    if (resolve_taken) begin
                        ctr_d[r_idx]    = (ctr_q[r_idx] == CTR_ST) ? CTR_ST
                                                                   : ctr_q[r_idx] + 2'd1;
                        target_d[r_idx] = resolve_target;
                    end else begin
                        ctr_d[r_idx]    = (ctr_q[r_idx] == CTR_SNT) ? CTR_SNT
                                                                    : ctr_q[r_idx] - 2'd1;
                    end
                end else if (resolve_taken) begin
                    // Allocate weakly taken, evicting whatever occupied the slot.
                    valid_d[r_idx]  = 1'b1;
                    tag_d[r_idx]    = r_tag;
                    target_d[r_idx] = resolve_target;
                    ctr_d[r_idx]    = CTR_WT;
                end
            end else if (id_pred_taken_q) begin
                valid_d[r_idx] = 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // IF/ID prediction register: flush/mispredict > hold > load
    // ------------------------------------------------------------------
    always_comb begin
        id_valid_d       = id_valid_q;
        id_pc_d          = id_pc_q;
        id_pred_taken_d  = id_pred_taken_q;
        id_pred_target_d = id_pred_target_q;
        if (flush || mispredict) begin
            // Drops both the held instruction and any wrong-path fetch.
            id_valid_d = 1'b0;
        end else if (!hold) begin
            id_valid_d       = fetch_valid;
            id_pc_d          = fetch_pc;
            id_pred_taken_d  = pred_taken;
            id_pred_target_d = pred_target;
        end
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                ctr_q[i]    <= CTR_WNT;
            end
            id_valid_q       <= 1'b0;
            id_pc_q          <= '0;
            id_pred_taken_q  <= 1'b0;
            id_pred_target_q <= '0;
        end else begin
            valid_q <= valid_d;
            for (int i = 0; i < ENTRIES; i++) begin
                tag_q[i]    <= tag_d[i];
                target_q[i] <= target_d[i];
                ctr_q[i]    <= ctr_d[i];
            end
            id_valid_q       <= id_valid_d;
            id_pc_q          <= id_pc_d;
            id_pred_taken_q  <= id_pred_taken_d;
            id_pred_target_q <= id_pred_target_d;
        end
    end

endmodule

// File: doc/branch_predictor.md
# branch_predictor

Dynamic branch predictor for the pipelined MIPS core's fetch stage. It looks up the fetch PC in a direct-mapped branch target buffer with 2-bit saturating counters and returns a predicted next PC. It keeps the prediction alongside the instruction in IF/ID. When the ID-stage branch comparison resolves, it checks the prediction, flags a mispredict with the correct redirect PC, and trains the table.

## Interface
Parameters:
- WIDTH, 32, datapath/PC width
- INDEX_BITS, 4, table index width (2^INDEX_BITS entries)

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- fetch_pc  in  WIDTH  PC being fetched (word aligned)
- fetch_valid  in  1  fetch_pc is a real fetch this cycle
- hold  in  1  IF/ID stall; held prediction must not change
- flush  in  1  IF/ID flush from hazard/jump logic
- pred_hit  out  1  fetch_pc hit a valid BTB entry
- pred_taken  out  1  predict taken
- pred_target  out  WIDTH  predicted next PC
- resolve_valid  in  1  ID instruction is a conditional branch (beq/bne)
- stall_compare  in  1  branch operands not ready; no resolution this cycle
- resolve_taken  in  1  actual outcome from the ID comparator
- resolve_target  in  WIDTH  computed branch target
- mispredict  out  1  redirect fetch this cycle
- redirect_pc  out  WIDTH  correct next PC when mispredict=1

## Operation
- **Indexing.** index = pc[INDEX_BITS+1:2]; tag = pc[WIDTH-1:INDEX_BITS+2].
- **Entry contents.** valid, tag, target[WIDTH], ctr[1:0].
- **Counter encoding.** 00 SNT, 01 WNT, 10 WT, 11 ST.
- **Lookup (combinational).**
  - hit = valid & tag match.
  - pred_taken = hit & ctr[1].
  - pred_target = pred_taken ? target : fetch_pc+4. The +4 wraps modulo 2^WIDTH.
- **Held register (id_valid, id_pc, id_pred_taken, id_pred_target).** Next-state priority per edge:
  1. flush or mispredict: id_valid←0.
  2. else if hold: keep all fields.
  3. else: id_valid←fetch_valid, and load fetch_pc and the prediction.
- **Resolution (combinational)** occurs when id_valid & !stall_compare.
  - Branch (resolve_valid=1): mispredict = (resolve_taken ≠ id_pred_taken) | (resolve_taken & resolve_target ≠ id_pred_target). redirect_pc = resolve_taken ? resolve_target : id_pc+4.
  - Non-branch predicted taken (resolve_valid=0 & id_pred_taken=1, e.g. a stale entry): mispredict=1, redirect_pc = id_pc+4.
  - Otherwise mispredict=0. When mispredict=0, redirect_pc is don't-care; drive id_pc+4.
- **Table update (at the edge ending the resolve cycle)**, only when resolution occurred:
  - Branch, hit: ctr saturating ±1 toward the outcome (11 stays 11, 00 stays 00). When taken, target←resolve_target.
  - Branch, miss, taken: allocate valid=1, tag, target=resolve_target, ctr=10. This replaces any previous occupant.
  - Branch, miss, not taken: no change.
  - Non-branch predicted taken: entry at id_pc index has valid←0.
- **stall_compare=1:** mispredict=0 and no update. The hazard unit also asserts hold, so the held branch resolves in a later cycle.

## Timing
- **Reset (async, immediate).**
  - All entries valid=0, ctr=01; id_valid=0.
  - Hence pred_hit=0, pred_taken=0, pred_target=fetch_pc+4, mispredict=0, redirect_pc=id_pc+4 with id_pc=0.
  - Reset mid-operation discards all training and the held prediction.
- **Latencies.**
  - Lookup: 0 cycles.
  - Prediction: reaches ID one cycle after fetch.
  - mispredict: asserted in the same cycle as the ID comparison.
  - Table update: visible to lookups from the next cycle.
- **Same-index read/write in one cycle:** the lookup returns the pre-update contents (no bypass).
- **mispredict & hold together:** mispredict wins and the held register clears.
- **mispredict & fetch_valid together:** the fetched (wrong-path) instruction is dropped.

## Test plan
- **Reset state.** Release rst_n with fetch_pc=0x100 → pred_hit=0, pred_taken=0, pred_target=0x104, mispredict=0.
- **Cold taken branch, then retrain.**
  - Fetch 0x40 (miss), then resolve taken, target 0x80 → mispredict=1, redirect_pc=0x80.
  - Next fetch of 0x40 → pred_hit=1, pred_taken=1 (ctr=10), pred_target=0x80.
- **Counter hysteresis.** Entry at 0x40 with ctr=11:
  - One not-taken resolve → mispredict=1, redirect_pc=0x44, ctr=10; next fetch still predicts taken.
  - Second not-taken → ctr=01; next fetch predicts not-taken, pred_target=0x44.
- **stall_compare.** Held branch with a mismatching outcome and stall_compare=1 for 2 cycles → mispredict=0 and the table is unchanged. Drop stall_compare → mispredict=1 in that cycle and the update applies.
- **Aliasing and stale entry.**
  - 0x40 trained taken; fetch 0x80 (same index, different tag) → pred_hit=0.
  - Fetch 0x40 with resolve_valid=0 → mispredict=1, redirect_pc=0x44, entry invalidated.
- **Flush/hold priority.**
  - flush with fetch_valid=1 → next cycle id_valid=0 and no resolution occurs.
  - hold for 3 cycles → the held prediction is unchanged across all 3.
